// File: rtl/spi_ram_pkg.sv
// Shared command encoding and field widths for the SPI-attached RAM controller.
package spi_ram_pkg;
  localparam int CMD_W     = 2;
  localparam int PAYLOAD_W = 8;
  localparam int RX_W      = CMD_W + PAYLOAD_W;

  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;
endpackage

// File: rtl/sp_ram.sv
// Single-port storage array: synchronous write, synchronous read into a
// registered output that only changes when a read is issued.
module sp_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // One access per cycle; rdata holds its value between reads
  always_ff @(posedge clk) begin
    if (we)      mem[addr] <= wdata;
    else if (re) rdata     <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between the SPI slave word stream and a single-port RAM.
// rx_data = {cmd[1:0], payload[7:0]}; read bytes return on tx_data/tx_valid.
// Optional build macro ADDR_AUTOINC_EN: post-increment wr_addr after each
// WR_DATA and rd_addr after each accepted RD_DATA (wrapping mod MEM_DEPTH).
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RX_W-1:0] rx_data,
  input  logic            rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic            tx_valid,
  output logic            cmd_err
);

  logic [CMD_W-1:0]     cmd;
  logic [PAYLOAD_W-1:0] payload;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, ram_addr;
  logic [DATA_W-1:0]    ram_rdata;
  logic                 rd_addr_ok;
  logic                 have_read;
  logic                 do_wr, do_rd, rd_bad;

  assign cmd     = rx_data[RX_W-1 -: CMD_W];
  assign payload = rx_data[PAYLOAD_W-1:0];

  // Decode the strobe into RAM accesses and the error case
  always_comb begin
    do_wr    = rx_valid && (cmd == CMD_WR_DATA);
    do_rd    = rx_valid && (cmd == CMD_RD_DATA) && rd_addr_ok;
    rd_bad   = rx_valid && (cmd == CMD_RD_DATA) && !rd_addr_ok;
    ram_addr = do_wr ? wr_addr : rd_addr;
  end

  // Address registers and the read-address-seen flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      rd_addr_ok <= 1'b0;
    end else if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
        CMD_RD_ADDR: begin
          rd_addr    <= payload[ADDR_SIZE-1:0];
          rd_addr_ok <= 1'b1;
        end
`ifdef ADDR_AUTOINC_EN
        CMD_WR_DATA: wr_addr <= wr_addr + ADDR_SIZE'(1);
        CMD_RD_DATA: if (rd_addr_ok) rd_addr <= rd_addr + ADDR_SIZE'(1);
`endif
        default: ;
      endcase
    end
  end

  // tx_valid is a level held until the next command; an erroring read leaves
  // it alone. have_read gates the RAM output so tx_data reads 0 until the
  // first accepted read after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid  <= 1'b0;
      have_read <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_err <= rd_bad;
      if (do_rd) begin
        tx_valid  <= 1'b1;
        have_read <= 1'b1;
      end else if (rx_valid && !rd_bad) begin
        tx_valid  <= 1'b0;
      end
    end
  end

  // RAM output register only changes on a read, so tx_data is stable while tx_valid=1
  assign tx_data = have_read ? ram_rdata : '0;

  sp_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_W    (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_wr),
    .re    (do_rd),
    .addr  (ram_addr),
    .wdata (payload[DATA_W-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl. Inputs change on negedge;
// outputs are sampled on the following negedge (or mid-cycle for async reset).
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       cmd_err;

  int nvec = 0;
  int nerr = 0;

`ifdef ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  spi_ram_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  // One-cycle command strobe; returns on the negedge after the capturing posedge
  task automatic send(input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    rx_data  = {c, p};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || cmd_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset: tx_valid=%b tx_data=%h cmd_err=%b, want 0/00/0", tx_valid, tx_data, cmd_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rd_err();
    send(2'b11, 8'h00);
    nvec++;
    if (cmd_err !== 1'b1 || tx_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rd_err_pulse: cmd_err=%b tx_valid=%b, want 1/0", cmd_err, tx_valid);
    end
    @(negedge clk);
    nvec++;
    if (cmd_err !== 1'b0 || tx_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rd_err_clear: cmd_err=%b tx_valid=%b, want 0/0", cmd_err, tx_valid);
    end
  endtask

  task automatic test_write_read();
    send(2'b00, 8'h12);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h12);
    nvec++;
    if (tx_valid !== 1'b0) begin
      nerr++;
      $display("FAIL wr_rd_pre: tx_valid=%b, want 0", tx_valid);
    end
    send(2'b11, 8'h00);
    nvec++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || cmd_err !== 1'b0) begin
      nerr++;
      $display("FAIL wr_rd_data: tx_valid=%b tx_data=%h cmd_err=%b, want 1/a5/0", tx_valid, tx_data, cmd_err);
    end
    repeat (5) @(negedge clk);
    nvec++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      nerr++;
      $display("FAIL wr_rd_hold: tx_valid=%b tx_data=%h, want 1/a5", tx_valid, tx_data);
    end
    send(2'b00, 8'h40);
    nvec++;
    if (tx_valid !== 1'b0) begin
      nerr++;
      $display("FAIL wr_rd_clear: tx_valid=%b, want 0", tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp2;
    int bad;
    exp2 = AUTOINC ? 8'h5A : 8'hA5;
    send(2'b00, 8'h13);
    send(2'b01, 8'h5A);
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    nvec++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      nerr++;
      $display("FAIL b2b_first: tx_valid=%b tx_data=%h, want 1/a5", tx_valid, tx_data);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL b2b_idle: %0d idle cycles lost tx_valid/tx_data, want 0", bad);
    end
    // Second read: sample tx_valid in the cycle the command is captured too
    @(negedge clk);
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if (tx_valid !== 1'b1 || tx_data !== exp2) begin
      nerr++;
      $display("FAIL b2b_second: tx_valid=%b tx_data=%h, want 1/%h", tx_valid, tx_data, exp2);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic test_burst();
    logic [7:0] exp1, chk_addr;
    exp1     = AUTOINC ? 8'h11 : 8'h22;
    chk_addr = AUTOINC ? 8'h01 : 8'hFF;
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);
    nvec++;
    if (tx_valid !== 1'b1 || tx_data !== exp1) begin
      nerr++;
      $display("FAIL burst_rd0: tx_valid=%b tx_data=%h, want 1/%h", tx_valid, tx_data, exp1);
    end
    send(2'b11, 8'h00);
    nvec++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
      nerr++;
      $display("FAIL burst_rd1: tx_valid=%b tx_data=%h, want 1/22", tx_valid, tx_data);
    end
    // Probe where wr_addr ended up by writing a marker and reading it back
    send(2'b01, 8'h33);
    send(2'b10, chk_addr);
    send(2'b11, 8'h00);
    nvec++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h33) begin
      nerr++;
      $display("FAIL burst_wr_addr: tx_data=%h at %h, want 33", tx_data, chk_addr);
    end
  endtask

  task automatic test_mid_reset();
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    nvec++;
    if (tx_valid !== 1'b1) begin
      nerr++;
      $display("FAIL mid_rst_pre: tx_valid=%b, want 1", tx_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      nerr++;
      $display("FAIL mid_rst_async: tx_valid=%b tx_data=%h, want 0/00", tx_valid, tx_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b11, 8'h00);
    nvec++;
    if (cmd_err !== 1'b1 || tx_valid !== 1'b0) begin
      nerr++;
      $display("FAIL mid_rst_err: cmd_err=%b tx_valid=%b, want 1/0", cmd_err, tx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_rd_err();
    test_write_read();
    test_back_to_back();
    test_burst();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard stop in case a task stalls
  initial begin
    #100000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

endmodule
